// File: rtl/term_pkg.sv
// Shared constants and state encoding for the font-terminal write path.
package term_pkg;

   localparam int TERM_ADDR_W = 8;
   localparam int TERM_CHAR_W = 6;
   localparam int TERM_COLS   = 80;
   localparam int TERM_ROWS   = 30;

   localparam logic [TERM_CHAR_W-1:0] CHAR_BLANK = 6'h3F;

   typedef enum logic {
      StClear = 1'b0,
      StArb   = 1'b1
   } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0] i_req,
   input  logic [2:0]   i_ptr,
   output logic [N-1:0] o_grant,
   output logic [2:0]   o_idx,
   output logic         o_any
);

   always_comb begin
      int j;
      logic w_found;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!w_found && i_req[j]) begin
            w_found    = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = 3'(j);
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/term_write_scheduler.sv
// Shares the terminal write port among N_REQ producers, clearing the screen on reset/request.
module term_write_scheduler
   import term_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int COLS  = TERM_COLS,
   parameter int ROWS  = TERM_ROWS,
   parameter logic [TERM_CHAR_W-1:0] BLANK_CHAR = CHAR_BLANK
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [TERM_ADDR_W*N_REQ-1:0] req_h,
   input  logic [TERM_ADDR_W*N_REQ-1:0] req_v,
   input  logic [TERM_CHAR_W*N_REQ-1:0] req_char,
   input  logic                         clear_req,
   output logic                         busy,
   output logic [TERM_ADDR_W-1:0]       term_h,
   output logic [TERM_ADDR_W-1:0]       term_v,
   output logic [TERM_CHAR_W-1:0]       term_char,
   output logic                         term_w_en,
   output logic [2:0]                   grant_id,
   output logic                         oob_drop
);

   sched_state_e r_state, w_state_d;
   logic [TERM_ADDR_W-1:0] r_clr_h, r_clr_v;
   logic [2:0]             r_ptr;
   logic [TERM_ADDR_W-1:0] r_term_h, r_term_v;
   logic [TERM_CHAR_W-1:0] r_term_char;
   logic                   r_w_en, r_oob;
   logic [2:0]             r_grant_id;

   logic [N_REQ-1:0]       w_req_arb, w_grant;
   logic [2:0]             w_idx;
   logic                   w_any;
   logic [TERM_ADDR_W-1:0] w_h, w_v;
   logic [TERM_CHAR_W-1:0] w_char;
   logic                   w_in_range, w_clr_last;

   // Requests are hidden from the arbiter outside ARB and during a clear pulse.
   assign w_req_arb = (r_state == StArb && !clear_req) ? req_valid : '0;

   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .i_req   (w_req_arb),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign req_ready = w_grant;

   always_comb begin
      w_h    = '0;
      w_v    = '0;
      w_char = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_idx == 3'(i)) begin
            w_h    = req_h[TERM_ADDR_W*i +: TERM_ADDR_W];
            w_v    = req_v[TERM_ADDR_W*i +: TERM_ADDR_W];
            w_char = req_char[TERM_CHAR_W*i +: TERM_CHAR_W];
         end
      end
   end

   assign w_in_range = (int'(w_h) < COLS) && (int'(w_v) < ROWS);
   assign w_clr_last = (int'(r_clr_h) == COLS - 1) && (int'(r_clr_v) == ROWS - 1);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StClear: if (w_clr_last && !clear_req) w_state_d = StArb;
         StArb:   if (clear_req) w_state_d = StClear;
         default: w_state_d = StClear;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= StClear;
         r_clr_h     <= '0;
         r_clr_v     <= '0;
         r_ptr       <= '0;
         r_term_h    <= '0;
         r_term_v    <= '0;
         r_term_char <= '0;
         r_w_en      <= 1'b0;
         r_oob       <= 1'b0;
         r_grant_id  <= '0;
      end else begin
         r_state <= w_state_d;
         r_oob   <= 1'b0;
         r_w_en  <= 1'b0;
         if (r_state == StClear) begin
            r_w_en      <= 1'b1;
            r_term_h    <= r_clr_h;
            r_term_v    <= r_clr_v;
            r_term_char <= BLANK_CHAR;
            if (clear_req || w_clr_last) begin
               r_clr_h <= '0;
               r_clr_v <= '0;
            end else if (int'(r_clr_h) == COLS - 1) begin
               r_clr_h <= '0;
               r_clr_v <= r_clr_v + 1'b1;
            end else begin
               r_clr_h <= r_clr_h + 1'b1;
            end
         end else if (clear_req) begin
            r_clr_h <= '0;
            r_clr_v <= '0;
         end else if (w_any) begin
            r_ptr <= (int'(w_idx) == N_REQ - 1) ? 3'd0 : w_idx + 3'd1;
            if (w_in_range) begin
               r_w_en      <= 1'b1;
               r_term_h    <= w_h;
               r_term_v    <= w_v;
               r_term_char <= w_char;
               r_grant_id  <= w_idx;
            end else begin
               r_oob <= 1'b1;
            end
         end
      end
   end

   assign busy      = (r_state == StClear);
   assign term_h    = r_term_h;
   assign term_v    = r_term_v;
   assign term_char = r_term_char;
   assign term_w_en = r_w_en;
   assign grant_id  = r_grant_id;
   assign oob_drop  = r_oob;

endmodule

// File: doc/term_write_scheduler.md
Name: term_write_scheduler

Overview:
- Owns the single write port of the font terminal character buffer and shares it between N_REQ independent text producers, such as the note display, key echo and status line.
- On reset, and on explicit request, it clears the whole screen to a blank character before granting any producer.
- Between clears it round-robin arbitrates producer writes, one character per cycle, and drives the terminal's registered write interface.

Parameters:
N_REQ, 3, number of requesters (2..8)
COLS, 80, terminal columns; valid h is 0..COLS-1
ROWS, 30, terminal rows; valid v is 0..ROWS-1
BLANK_CHAR, 6'h3F, character code written during a clear

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
req_valid  in  N_REQ  per-requester write request
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_h  in  8*N_REQ  column; requester i uses bits [8i+7:8i]
req_v  in  8*N_REQ  row; same packing as req_h
req_char  in  6*N_REQ  character code; requester i uses bits [6i+5:6i]
clear_req  in  1  single-cycle pulse: re-clear the screen
busy  out  1  high while in CLEAR
term_h  out  8  terminal write column
term_v  out  8  terminal write row
term_char  out  6  terminal write character
term_w_en  out  1  terminal write strobe
grant_id  out  3  index of the requester whose write is on term_* this cycle
oob_drop  out  1  1-cycle pulse: an accepted write was out of range and discarded

Behaviour:
- Reset (rst==0): term_w_en=0; term_h/v/char=0; grant_id=0; oob_drop=0; rr pointer=0; clear counters=(0,0); state=CLEAR; busy=1.
- States: CLEAR, ARB.
- CLEAR:
  - req_ready all 0.
  - Each cycle writes BLANK_CHAR at (clr_h, clr_v) with term_w_en=1, registered.
  - h increments fastest; at h=COLS-1, h wraps to 0 and v increments.
  - After writing (COLS-1, ROWS-1), go to ARB on the next cycle; busy falls with that transition.
  - A full clear is exactly COLS*ROWS write cycles (2400 at defaults).
- ARB:
  - Winner = first i with req_valid[i]=1, searching i = ptr, ptr+1, ... mod N_REQ.
  - req_ready[winner]=1 combinationally; req_ready depends on req_valid, and requesters must not make valid depend on ready.
  - A transfer occurs when valid&ready at edge t. At t+1: term_h/v/char = captured values, grant_id = winner, term_w_en=1. Latency is 1 cycle.
  - On a transfer, ptr = (winner+1) mod N_REQ. With no transfer, ptr holds.
  - If there are no valid requests, term_w_en=0 and term_h/v/char/grant_id hold their last values.
- Out of range (h>=COLS or v>=ROWS): the request is still accepted (ready=1, ptr advances). At t+1, term_w_en=0 and oob_drop=1.
- Requesters hold h/v/char stable while valid and not ready; ready may stay low indefinitely under contention.
- clear_req:
  - Sampled in every state.
  - In ARB, during a cycle with clear_req=1, all req_ready=0 (no transfer); go to CLEAR with counters=(0,0). A write already registered from the previous cycle still completes.
  - In CLEAR, the counters restart at (0,0).
  - Simultaneous with rst==0, reset wins (same result).
- Reset mid-clear or mid-traffic: immediate return to the reset state; the scan restarts at (0,0).
- Counter widths: clr_h 8 bits, clr_v 8 bits; never exceed COLS-1 / ROWS-1.

Decomposition:
- Shared package term_pkg:
  - TERM_ADDR_W=8, TERM_CHAR_W=6
  - TERM_COLS=80, TERM_ROWS=30
  - CHAR_BLANK=6'h3F
  - state encoding enum (CLEAR, ARB)
- One sub-module: rr_arbiter (N parameter).
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, winner index, any.
  - Purely combinational.
- The scheduler holds the FSM, clear counters, ptr and output registers.

Test Plan:
1. Release rst after 2 cycles, all req_valid=0 -> exactly 2400 consecutive term_w_en cycles, char 6'h3F; first write (0,0), (79,0) followed by (0,1), last (79,29); busy falls after the last write; no req_ready during the clear.
2. After the clear, req0 valid with (5,2,6'h0C) -> req_ready[0] the same cycle; next cycle term_w_en=1, term_h=5, term_v=2, term_char=6'h0C, grant_id=0.
3. All three valid continuously with distinct chars -> grants rotate 0,1,2,0,1,2; one write per cycle; no requester starved more than 2 cycles.
4. req1 with h=80, v=3 -> accepted; next cycle term_w_en=0, oob_drop=1; ptr advances so req2 wins next if valid.
5. Pulse clear_req while req0/req1 stream -> no ready in the pulse cycle; a full 2400-write clear follows; arbitration then resumes at the saved ptr.
6. Drive rst=0 for 1 cycle at write 1000 of the clear -> outputs return to reset values; a fresh 2400-write clear starting at (0,0) follows.
